// File: rtl/mem_tile_bank_arbiter.sv
// Round-robin arbiter sharing one latency-1 single-port SRAM bank between
// NumReq requesters. Read data returns to the granted requester one cycle
// after the grant. Optional zeroization sweep after reset is compiled in by
// defining MEM_TILE_ARB_ZEROIZE_EN.
module mem_tile_bank_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned NumWords  = 512,
  parameter int unsigned DataWidth = 256,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                req_i,
  output logic [NumReq-1:0]                gnt_o,
  input  logic [NumReq-1:0]                we_i,
  input  logic [NumReq*AddrWidth-1:0]      addr_i,
  input  logic [NumReq*DataWidth-1:0]      wdata_i,
  input  logic [NumReq*(DataWidth/8)-1:0]  be_i,
  output logic [NumReq-1:0]                rvalid_o,
  output logic [NumReq*DataWidth-1:0]      rdata_o,
  output logic                             sram_req_o,
  output logic                             sram_we_o,
  output logic [AddrWidth-1:0]             sram_addr_o,
  output logic [DataWidth-1:0]             sram_wdata_o,
  output logic [DataWidth/8-1:0]           sram_be_o,
  input  logic [DataWidth-1:0]             sram_rdata_i,
  output logic                             init_done_o
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned RrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

`ifdef MEM_TILE_ARB_ZEROIZE_EN
  typedef enum logic {INIT, RUN} state_e;
  logic [AddrWidth-1:0] init_cnt_q;
`else
  typedef enum logic {RUN} state_e;
`endif

  state_e state_q, state_d;

  logic [RrWidth-1:0] rr_q, rr_next;
  logic [RrWidth-1:0] owner_q;
  logic               pend_q;
  logic [RrWidth-1:0] win_idx;
  logic               win_valid;
  logic [RrWidth-1:0] cand;
  int unsigned        sum;

  // State register (and zeroization counter when compiled in)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef MEM_TILE_ARB_ZEROIZE_EN
      state_q    <= INIT;
      init_cnt_q <= '0;
`else
      state_q    <= RUN;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_TILE_ARB_ZEROIZE_EN
      if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;
`endif
    end
  end

  // Next-state: leave INIT after the last word has been cleared
  always_comb begin
    state_d = state_q;
`ifdef MEM_TILE_ARB_ZEROIZE_EN
    if (state_q == INIT && init_cnt_q == AddrWidth'(NumWords - 1)) state_d = RUN;
`endif
  end

  // Round-robin scan starting at rr_q, wrapping modulo NumReq
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    sum       = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      sum = int'(rr_q) + i;
      if (sum >= NumReq) sum = sum - NumReq;
      cand = RrWidth'(sum);
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
    rr_next = (win_idx == RrWidth'(NumReq - 1)) ? '0 : win_idx + 1'b1;
  end

  // Outputs: grant and SRAM mux in RUN, clearing writes in INIT, idle otherwise
  always_comb begin
    gnt_o        = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
`ifdef MEM_TILE_ARB_ZEROIZE_EN
    init_done_o  = !rst_i && (state_q == RUN);
`else
    init_done_o  = 1'b1;
`endif
    if (!rst_i) begin
      if (state_q == RUN) begin
        for (int unsigned j = 0; j < NumReq; j++) begin
          gnt_o[j] = win_valid && (win_idx == RrWidth'(j));
          if (gnt_o[j]) begin
            sram_we_o    = we_i[j];
            sram_addr_o  = addr_i[j*AddrWidth +: AddrWidth];
            sram_wdata_o = wdata_i[j*DataWidth +: DataWidth];
            sram_be_o    = be_i[j*BeWidth +: BeWidth];
          end
        end
        sram_req_o = win_valid;
      end
`ifdef MEM_TILE_ARB_ZEROIZE_EN
      else begin
        sram_req_o  = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = init_cnt_q;
        sram_be_o   = '1;
      end
`endif
    end
  end

  // Priority pointer and response ownership tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q    <= '0;
      owner_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      pend_q <= |gnt_o;
      if (|gnt_o) begin
        owner_q <= win_idx;
        rr_q    <= rr_next;
      end
    end
  end

  // Response steering: only the owner lane carries data, others read zero
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int unsigned j = 0; j < NumReq; j++) begin
      rvalid_o[j] = pend_q && (owner_q == RrWidth'(j));
      if (rvalid_o[j]) rdata_o[j*DataWidth +: DataWidth] = sram_rdata_i;
    end
  end

endmodule
